// File: rtl/sec_ded_encoder_28_pipe.sv
// SEC-DED encoder for 28-bit cache words with a two-stage valid/ready pipeline,
// one-shot error injection on the codeword and a saturating count of words
// delivered downstream. Check-bit equations match sec_ded_decoder_28.
module sec_ded_encoder_28_pipe #(
  parameter int unsigned CNT_W     = 16,
  parameter bit          INJECT_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [27:0]      data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [27:0]      data_o,
  output logic [6:0]       ecc_o,
  input  logic             inj_arm_i,
  input  logic [34:0]      inj_mask_i,
  output logic             inj_busy_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  // Data-bit membership of each check bit (bit n set = data bit n participates).
  localparam logic [27:0] M0 = 28'h6AAAD5B;
  localparam logic [27:0] M1 = 28'hB33366D;
  localparam logic [27:0] M2 = 28'h3C3C78E;
  localparam logic [27:0] M3 = 28'h3FC07F0;
  localparam logic [27:0] M4 = 28'h3FFF800;
  localparam logic [27:0] M5 = 28'hC000000;

  logic             vA_q, vB_q;
  logic [27:0]      dA_q, dB_q;
  logic [6:0]       eB_q;
  logic             busy_q;
  logic [34:0]      mask_q;
  logic [CNT_W-1:0] cnt_q;

  logic             advA, advB;
  logic             inj_apply;
  logic [5:0]       ecc_lo;
  logic [6:0]       ecc_full;
  logic [27:0]      dB_d;
  logic [6:0]       eB_d;

  // Handshake, check-bit generation and optional mask application between stages.
  always_comb begin
    advB      = ~vB_q | ready_i;
    advA      = ~vA_q | advB;
    ecc_lo[0] = ^(dA_q & M0);
    ecc_lo[1] = ^(dA_q & M1);
    ecc_lo[2] = ^(dA_q & M2);
    ecc_lo[3] = ^(dA_q & M3);
    ecc_lo[4] = ^(dA_q & M4);
    ecc_lo[5] = ^(dA_q & M5);
    ecc_full  = {(^dA_q) ^ (^ecc_lo), ecc_lo};
    inj_apply = INJECT_EN && busy_q && advB && vA_q;
    {eB_d, dB_d} = {ecc_full, dA_q} ^ (inj_apply ? mask_q : '0);
  end

  // Two pipeline stages; stage B holds while the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vA_q <= 1'b0;
      dA_q <= '0;
      vB_q <= 1'b0;
      dB_q <= '0;
      eB_q <= '0;
    end else begin
      if (advA) begin
        vA_q <= valid_i;
        if (valid_i) dA_q <= data_i;
      end
      if (advB) begin
        vB_q <= vA_q;
        if (vA_q) begin
          dB_q <= dB_d;
          eB_q <= eB_d;
        end
      end
    end
  end

  // One-shot injection: arm captures the mask, first A->B move after arming consumes it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      mask_q <= '0;
    end else if (INJECT_EN) begin
      if (!busy_q && inj_arm_i) begin
        busy_q <= 1'b1;
        mask_q <= inj_mask_i;
      end else if (inj_apply) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Saturating count of downstream handshakes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (vB_q && ready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ready_o    = advA;
  assign valid_o    = vB_q;
  assign data_o     = dB_q;
  assign ecc_o      = eB_q;
  assign inj_busy_o = busy_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_sec_ded_encoder_28_pipe.sv
// Bench for sec_ded_encoder_28_pipe: random and directed traffic against a
// queue-based model of in-flight words, plus a behavioural SEC-DED decode.
module tb_sec_ded_encoder_28_pipe;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_i, arm;
  logic [27:0] data_i;
  logic [34:0] mask;
  logic        ready_o, valid_o, busy;
  logic [27:0] data_o;
  logic [6:0]  ecc_o;
  logic [15:0] cnt;
  logic        ready4, valid4, busy4;
  logic [27:0] data4;
  logic [6:0]  ecc4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  sec_ded_encoder_28_pipe #(.CNT_W(16), .INJECT_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ecc_o(ecc_o),
    .inj_arm_i(arm), .inj_mask_i(mask), .inj_busy_o(busy), .word_cnt_o(cnt));

  sec_ded_encoder_28_pipe #(.CNT_W(4), .INJECT_EN(1'b1)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready4), .data_i(data_i),
    .valid_o(valid4), .ready_i(ready_i), .data_o(data4), .ecc_o(ecc4),
    .inj_arm_i(arm), .inj_mask_i(mask), .inj_busy_o(busy4), .word_cnt_o(cnt4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Check-bit participation lists, -1 pads unused slots.
  int grp [6][16] = '{
    '{0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26},
    '{0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27},
    '{1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,-1},
    '{4,5,6,7,8,9,10,18,19,20,21,22,23,24,25,-1},
    '{11,12,13,14,15,16,17,18,19,20,21,22,23,24,25,-1},
    '{26,27,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1,-1}};

  function automatic logic [6:0] ecc_ref(input logic [27:0] d);
    logic [6:0] e;
    e = '0;
    for (int g = 0; g < 6; g++)
      for (int k = 0; k < 16; k++)
        if (grp[g][k] >= 0) e[g] = e[g] ^ d[grp[g][k]];
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  // Behavioural decoder: returns {single, double, corrected data}.
  function automatic logic [29:0] decode(input logic [27:0] d, input logic [6:0] e);
    logic [6:0]  syn, col;
    logic        odd;
    logic [27:0] c;
    syn = ecc_ref(d) ^ e;
    odd = ^{d, e};
    c   = d;
    if (odd)
      for (int i = 0; i < 28; i++) begin
        col = ecc_ref(28'd1 << i);
        if (col[5:0] == syn[5:0]) c[i] = ~c[i];
      end
    return {odd, (!odd && syn != 7'd0), c};
  endfunction

  typedef struct {
    logic [34:0] cw;
    int          acc;
    bit          masked;
  } ent_t;

  ent_t        q[$];
  ent_t        f, nw;
  int          cyc = 0;
  int          hs = 0;
  logic [34:0] pend_mask;
  bit          pend_valid = 1'b0;
  bit          vexp, rexp;
  logic [29:0] dec;

  // Model: front word is in stage B once two cycles have passed since its acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      hs = 0;
      pend_valid = 1'b0;
    end else begin
      vexp = (q.size() > 0) && (cyc - q[0].acc >= 2);
      rexp = (q.size() < 2) || ready_i;
      chk(ready_o == rexp, "ready_o", 64'(ready_o), 64'(rexp));
      chk(valid_o == vexp, "valid_o", 64'(valid_o), 64'(vexp));
      if (vexp) begin
        f = q[0];
        chk({ecc_o, data_o} == f.cw, "codeword", 64'({ecc_o, data_o}), 64'(f.cw));
        if (!f.masked) begin
          dec = decode(data_o, ecc_o);
          chk(dec == {2'b00, f.cw[27:0]}, "decode_clean", 64'(dec), 64'({2'b00, f.cw[27:0]}));
        end
      end
      chk(cnt == 16'(hs), "word_cnt", 64'(cnt), 64'(hs));
      chk(cnt4 == 4'((hs > 15) ? 15 : hs), "word_cnt_sat4", 64'(cnt4), 64'((hs > 15) ? 15 : hs));
      chk({valid4, ready4, busy4, ecc4, data4} == {valid_o, ready_o, busy, ecc_o, data_o},
          "cnt4_instance", 64'({valid4, ready4, busy4, ecc4, data4}), 64'({valid_o, ready_o, busy, ecc_o, data_o}));
      if (vexp && ready_i) begin
        void'(q.pop_front());
        hs++;
      end
      if (valid_i && rexp) begin
        nw.cw     = {ecc_ref(data_i), data_i};
        nw.acc    = cyc;
        nw.masked = pend_valid;
        if (pend_valid) begin
          nw.cw      = nw.cw ^ pend_mask;
          pend_valid = 1'b0;
        end
        q.push_back(nw);
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle pipeline, ready_i=1: word appears exactly two cycles after acceptance.
  task automatic send_vec(input logic [27:0] d, input logic [6:0] e);
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    chk(valid_o == 1'b0, "vec_lat1", 64'(valid_o), 64'd0);
    tick();
    @(negedge clk);
    chk({valid_o, ecc_o, data_o} == {1'b1, e, d}, "vec", 64'({valid_o, ecc_o, data_o}), 64'({1'b1, e, d}));
    tick();
  endtask

  int          acc;
  logic [27:0] v;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; arm = 1'b0; data_i = '0; mask = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk({valid_o, ready_o, busy, cnt, ecc_o, data_o} == {3'b010, 51'd0}, "reset_state",
        64'({valid_o, ready_o, busy, cnt, ecc_o, data_o}), 64'({3'b010, 51'd0}));
    tick();

    send_vec(28'h0000000, 7'h00);
    send_vec(28'h0000001, 7'h43);
    send_vec(28'h4000000, 7'h61);
    send_vec(28'hFFFFFFF, 7'h5C);

    // Downstream stall while upstream streams 1,2,3...
    ready_i = 1'b0; valid_i = 1'b1; acc = 0; v = 28'd1;
    for (int i = 0; i < 5; i++) begin
      data_i = v;
      @(negedge clk);
      if (ready_o) begin acc++; v = v + 28'd1; end
      tick();
    end
    @(negedge clk);
    chk(acc == 2, "stall_accepts", 64'(acc), 64'd2);
    chk({ready_o, valid_o, data_o} == {2'b01, 28'd1}, "stall_hold", 64'({ready_o, valid_o, data_o}), 64'({2'b01, 28'd1}));
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < 30 && v < 28'd9; i++) begin
      data_i = v;
      @(negedge clk);
      if (ready_o) v = v + 28'd1;
      tick();
    end
    valid_i = 1'b0;
    repeat (4) tick();

    // Random valid/ready traffic.
    for (int i = 0; i < 4000; i++) begin
      valid_i = ($urandom_range(9) < 7);
      ready_i = ($urandom_range(9) < 7);
      data_i  = 28'($urandom);
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 500; i++) begin
      valid_i = $urandom_range(1);
      data_i  = 28'($urandom);
      tick();
    end
    valid_i = 1'b0;
    repeat (4) tick();

    // Injection of a single data-bit flip; a second arm while busy is ignored.
    arm = 1'b1; mask = 35'h20;
    @(negedge clk);
    chk(busy == 1'b0, "busy_before_arm", 64'(busy), 64'd0);
    tick();
    arm = 1'b1; mask = 35'h1;
    @(negedge clk);
    chk(busy == 1'b1, "busy_armed", 64'(busy), 64'd1);
    tick();
    arm = 1'b0; mask = '0;
    pend_mask = 35'h20; pend_valid = 1'b1;
    valid_i = 1'b1; data_i = 28'h0;
    @(negedge clk);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    chk(busy == 1'b1, "busy_held", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk({valid_o, ecc_o, data_o} == {1'b1, 7'h00, 28'h20}, "inj_single_word",
        64'({valid_o, ecc_o, data_o}), 64'({1'b1, 7'h00, 28'h20}));
    chk(busy == 1'b0, "busy_cleared", 64'(busy), 64'd0);
    dec = decode(data_o, ecc_o);
    chk(dec == {2'b10, 28'h0}, "inj_single_decode", 64'(dec), 64'({2'b10, 28'h0}));
    tick();
    send_vec(28'h0000000, 7'h00);

    // Word moving in the arm cycle stays clean; the next one takes a double flip.
    valid_i = 1'b1; data_i = 28'h5A5A5A5;
    @(negedge clk);
    tick();
    data_i = 28'h0ABCDEF; arm = 1'b1; mask = 35'h3;
    pend_mask = 35'h3; pend_valid = 1'b1;
    @(negedge clk);
    chk(busy == 1'b0, "busy_arm_cycle", 64'(busy), 64'd0);
    tick();
    valid_i = 1'b0; arm = 1'b0; mask = '0;
    @(negedge clk);
    chk(busy == 1'b1, "busy_second_arm", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk(busy == 1'b0, "busy_second_clear", 64'(busy), 64'd0);
    dec = decode(data_o, ecc_o);
    chk(dec[29:28] == 2'b01, "inj_double_decode", 64'(dec[29:28]), 64'd1);
    tick();
    repeat (2) tick();

    // Reset with both stages full and injection armed.
    ready_i = 1'b0; valid_i = 1'b1; data_i = 28'h111;
    tick();
    data_i = 28'h222;
    tick();
    valid_i = 1'b0; arm = 1'b1; mask = 35'h7FFFFFFFF;
    tick();
    arm = 1'b0; mask = '0;
    @(negedge clk);
    chk({busy, ready_o, valid_o} == 3'b101, "full_armed", 64'({busy, ready_o, valid_o}), 64'h5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    chk({valid_o, busy, cnt, ready_o} == {18'd0, 1'b1}, "post_reset",
        64'({valid_o, busy, cnt, ready_o}), 64'({18'd0, 1'b1}));
    tick();
    send_vec(28'h0000001, 7'h43);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
